// File: rtl/nand_seq_pkg.sv
// Shared constants for the NAND page-read sequencer: wrapper register map, command codes,
// error encoding, FSM state codes and the per-step CMD write data.
package nand_seq_pkg;

    localparam logic [7:0] DATA_REG_ADDR   = 8'h00;
    localparam logic [7:0] CMD_REG_ADDR    = 8'h04;
    localparam logic [7:0] STATUS_REG_ADDR = 8'h0C;

    localparam logic [7:0] CMD_RESET   = 8'h00;
    localparam logic [7:0] CMD_SEL     = 8'h0D;
    localparam logic [7:0] CMD_READ1   = 8'h01;
    localparam logic [7:0] CMD_READ2   = 8'h03;
    localparam logic [7:0] CMD_XFER    = 8'h0E;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_SLV     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_STEP_SETUP  = 3'd1;
    localparam logic [2:0] ST_STEP_ACCESS = 3'd2;
    localparam logic [2:0] ST_POLL_SETUP  = 3'd3;
    localparam logic [2:0] ST_POLL_ACCESS = 3'd4;
    localparam logic [2:0] ST_DRAIN       = 3'd5;
    localparam logic [2:0] ST_FINISH      = 3'd6;

    // Steps 0..4 are the setup writes, 5 is the per-byte 0x0E write, 6 is the DATA read.
    localparam logic [2:0] STEP_LAST_SETUP = 3'd4;
    localparam logic [2:0] STEP_XFER       = 3'd5;
    localparam logic [2:0] STEP_DATA       = 3'd6;

    function automatic logic [31:0] step_wdata(input logic [2:0] step, input logic [7:0] addr);
        case (step)
            3'd0:    step_wdata = {24'h0, CMD_RESET};
            3'd1:    step_wdata = {24'h0, CMD_SEL};
            3'd2:    step_wdata = {24'h0, addr};
            3'd3:    step_wdata = {24'h0, CMD_READ1};
            3'd4:    step_wdata = {24'h0, CMD_READ2};
            default: step_wdata = {24'h0, CMD_XFER};
        endcase
    endfunction

endpackage

// File: rtl/nand_apb_read_sequencer_if.sv
// APB bus between the read sequencer (master) and the NAND wrapper (slave).
interface nand_apb_read_sequencer_if #(parameter int ADDR_W = 16) ();
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_master_xfer.sv
// Single APB transfer engine: start in idle launches SETUP then ACCESS until PREADY.
// done/rdata/slverr are valid combinationally on the completing ACCESS cycle.
module apb_master_xfer #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              write,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              slverr,
    nand_apb_read_sequencer_if.master apb
);
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;

    always_comb begin
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        if (!psel_q && start) begin
            psel_d   = 1'b1;
            pwrite_d = write;
            paddr_d  = addr;
            pwdata_d = wdata;
        end else if (psel_q && !penable_q) begin
            penable_d = 1'b1;
        end else if (psel_q && penable_q && apb.PREADY) begin
            // Dropping PSEL here guarantees an idle cycle before the next SETUP.
            psel_d    = 1'b0;
            penable_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;

    assign busy   = psel_q;
    assign done   = psel_q & penable_q & apb.PREADY;
    assign rdata  = apb.PRDATA;
    assign slverr = apb.PSLVERR;
endmodule

// File: rtl/nand_apb_read_sequencer.sv
// Turns one page-read request into the wrapper CMD/STATUS/DATA APB sequence and
// streams the read bytes out; no APB traffic while a byte waits for dout_ready.
module nand_apb_read_sequencer
    import nand_seq_pkg::*;
#(
    parameter int POLL_MAX = 1024,
    parameter int ADDR_W   = 16
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_len,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic [7:0] dout_data,
    output logic       done,
    output logic [1:0] err,
    nand_apb_read_sequencer_if.master apb
);
    localparam int PCW = $clog2(POLL_MAX + 1);

    logic [2:0]        state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [PCW-1:0]    poll_q, poll_d;
    logic [1:0]        err_q, err_d;
    logic              dv_q, dv_d;
    logic [7:0]        dd_q, dd_d;

    logic              x_start, x_write, x_busy, x_done, x_slverr;
    logic [ADDR_W-1:0] x_addr;
    logic [31:0]       x_wdata, x_rdata;
    logic              rdata_unused;

    assign rdata_unused = ^x_rdata[31:8];

    apb_master_xfer #(.ADDR_W(ADDR_W)) u_xfer (
        .clk    (PCLK),
        .rst    (PRESET),
        .start  (x_start),
        .addr   (x_addr),
        .wdata  (x_wdata),
        .write  (x_write),
        .busy   (x_busy),
        .done   (x_done),
        .rdata  (x_rdata),
        .slverr (x_slverr),
        .apb    (apb)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        poll_d  = poll_q;
        err_d   = err_q;
        dv_d    = dv_q;
        dd_d    = dd_q;
        x_start = 1'b0;
        x_write = 1'b1;
        x_addr  = ADDR_W'(CMD_REG_ADDR);
        x_wdata = step_wdata(step_q, addr_q);
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    cnt_d   = req_len;
                    err_d   = ERR_OK;
                    step_d  = 3'd0;
                    state_d = ST_STEP_SETUP;
                end
            end
            ST_STEP_SETUP: begin
                x_start = !x_busy;
                if (step_q == STEP_DATA) begin
                    x_write = 1'b0;
                    x_addr  = ADDR_W'(DATA_REG_ADDR);
                    x_wdata = '0;
                end
                if (!x_busy) state_d = ST_STEP_ACCESS;
            end
            ST_STEP_ACCESS: begin
                if (x_done) begin
                    if (x_slverr) begin
                        err_d   = ERR_SLV;
                        state_d = ST_FINISH;
                    end else if (step_q == STEP_DATA) begin
                        dd_d    = x_rdata[7:0];
                        dv_d    = 1'b1;
                        cnt_d   = cnt_q - 8'd1;
                        state_d = ST_DRAIN;
                    end else begin
                        poll_d  = '0;
                        state_d = ST_POLL_SETUP;
                    end
                end
            end
            ST_POLL_SETUP: begin
                x_start = !x_busy;
                x_write = 1'b0;
                x_addr  = ADDR_W'(STATUS_REG_ADDR);
                x_wdata = '0;
                if (!x_busy) state_d = ST_POLL_ACCESS;
            end
            ST_POLL_ACCESS: begin
                if (x_done) begin
                    if (x_slverr) begin
                        err_d   = ERR_SLV;
                        state_d = ST_FINISH;
                    end else if (!x_rdata[0]) begin
                        if (step_q == STEP_LAST_SETUP && cnt_q == 8'd0) begin
                            state_d = ST_FINISH;
                        end else begin
                            step_d  = step_q + 3'd1;
                            state_d = ST_STEP_SETUP;
                        end
                    end else if (poll_q == PCW'(POLL_MAX - 1)) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = ST_FINISH;
                    end else begin
                        poll_d  = poll_q + PCW'(1);
                        state_d = ST_POLL_SETUP;
                    end
                end
            end
            ST_DRAIN: begin
                if (dout_ready) begin
                    dv_d = 1'b0;
                    if (cnt_q == 8'd0) begin
                        state_d = ST_FINISH;
                    end else begin
                        step_d  = STEP_XFER;
                        state_d = ST_STEP_SETUP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
            step_q  <= 3'd0;
            addr_q  <= 8'd0;
            cnt_q   <= 8'd0;
            poll_q  <= '0;
            err_q   <= ERR_OK;
            dv_q    <= 1'b0;
            dd_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            poll_q  <= poll_d;
            err_q   <= err_d;
            dv_q    <= dv_d;
            dd_q    <= dd_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign done       = (state_q == ST_FINISH);
    assign err        = err_q;
    assign dout_valid = dv_q;
    assign dout_data  = dd_q;
endmodule

// File: tb/tb_nand_apb_read_sequencer.sv
// Bench for nand_apb_read_sequencer: APB slave model, transfer and byte scoreboards.
module tb_nand_apb_read_sequencer;
    localparam int PM = 8;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       req_valid, req_ready;
    logic [7:0] req_addr, req_len;
    logic       dout_valid, dout_ready;
    logic [7:0] dout_data;
    logic       done;
    logic [1:0] err;

    nand_apb_read_sequencer_if #(.ADDR_W(16)) apb ();

    nand_apb_read_sequencer #(.POLL_MAX(PM), .ADDR_W(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .done(done), .err(err), .apb(apb.master)
    );

    always #5 PCLK = ~PCLK;

    typedef struct { bit wr; logic [15:0] addr; logic [31:0] data; int n; } xfer_t;
    xfer_t      exp_q[$];
    logic [7:0] exp_bytes[$];
    int vectors = 0, errors = 0, done_cnt = 0, beats = 0;

    // Slave model configuration and state
    bit          stall_en = 0, slverr_en = 0, stuck = 0;
    logic [31:0] stall_val = 0, slverr_val = 0;
    int          stall_n = 0, busy_n = 0, busy_left = 0, wait_left = 0;
    logic [7:0]  data_byte = 8'h00;
    bit          run_active = 0;
    int          run_cnt = 0;
    xfer_t       mon_e;
    logic [7:0]  mon_b;

    task automatic close_run();
        xfer_t s;
        run_active = 0;
        vectors++;
        if (exp_q.size() == 0 || exp_q[0].addr != 16'h000C) begin
            errors++;
            $display("FAIL status_poll_unexpected got %0d STATUS reads, required none", run_cnt);
        end else begin
            s = exp_q.pop_front();
            if ((s.n > 0 && run_cnt != s.n) || (s.n < 0 && run_cnt < -s.n)) begin
                errors++;
                $display("FAIL status_poll_count got %0d reads, required %0d (negative = at least)", run_cnt, s.n);
            end
        end
    endtask

    always begin
        @(negedge PCLK);
        #1;
        if (busy_left > 0) busy_left--;
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
        if (apb.PSEL && !apb.PENABLE) begin
            wait_left = (stall_en && apb.PWRITE && apb.PADDR == 16'h0004 && apb.PWDATA == stall_val) ? stall_n : 0;
        end else if (apb.PSEL && apb.PENABLE) begin
            if (wait_left > 0) begin
                wait_left--;
            end else begin
                apb.PREADY = 1'b1;
                if (!apb.PWRITE)
                    apb.PRDATA = (apb.PADDR == 16'h000C) ? {31'h0, (stuck || busy_left != 0)} : {24'hABCDEF, data_byte};
                if (slverr_en && apb.PWRITE && apb.PADDR == 16'h0004 && apb.PWDATA == slverr_val)
                    apb.PSLVERR = 1'b1;
                if (!apb.PWRITE && apb.PADDR == 16'h000C) begin
                    if (!run_active) begin
                        run_active = 1;
                        run_cnt = 0;
                    end
                    run_cnt++;
                end else begin
                    if (run_active) close_run();
                    vectors++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL apb_extra got wr=%0d addr=%h data=%h, required no transfer", apb.PWRITE, apb.PADDR, apb.PWDATA);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.wr != apb.PWRITE || mon_e.addr !== apb.PADDR || (mon_e.wr && mon_e.data !== apb.PWDATA)) begin
                            errors++;
                            $display("FAIL apb_xfer got wr=%0d addr=%h data=%h, required wr=%0d addr=%h data=%h",
                                     apb.PWRITE, apb.PADDR, apb.PWDATA, mon_e.wr, mon_e.addr, mon_e.data);
                        end
                    end
                    if (!apb.PWRITE) data_byte++;
                    if (apb.PWRITE && apb.PWDATA == 32'h0E) busy_left = busy_n;
                end
            end
        end
        if (dout_valid && dout_ready) begin
            beats++;
            vectors++;
            if (exp_bytes.size() == 0) begin
                errors++;
                $display("FAIL dout_extra got %h, required no byte", dout_data);
            end else begin
                mon_b = exp_bytes.pop_front();
                if (dout_data !== mon_b) begin
                    errors++;
                    $display("FAIL dout_data got %h, required %h", dout_data, mon_b);
                end
            end
        end
        if (done) begin
            done_cnt++;
            if (run_active) close_run();
        end
    end

    task automatic push_w(input logic [31:0] d, input int n);
        xfer_t t;
        t.wr = 1; t.addr = 16'h0004; t.data = d; t.n = 1;
        exp_q.push_back(t);
        if (n != 0) begin
            t.wr = 0; t.addr = 16'h000C; t.data = 0; t.n = n;
            exp_q.push_back(t);
        end
    endtask

    task automatic push_r();
        xfer_t t;
        t.wr = 0; t.addr = 16'h0000; t.data = 0; t.n = 1;
        exp_q.push_back(t);
    endtask

    task automatic push_setup(input logic [7:0] a);
        push_w(32'h00, 1);
        push_w(32'h0D, 1);
        push_w({24'h0, a}, 1);
        push_w(32'h01, 1);
        push_w(32'h03, 1);
    endtask

    task automatic push_bytes(input int len, input int npoll, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            push_w(32'h0E, npoll);
            push_r();
            exp_bytes.push_back(base + 8'(i));
        end
    endtask

    task automatic slave_clear(input logic [7:0] base);
        stall_en = 0; slverr_en = 0; stuck = 0; busy_n = 0;
        busy_left = 0; wait_left = 0; data_byte = base;
    endtask

    task automatic start_req(input logic [7:0] a, input logic [7:0] l);
        @(negedge PCLK);
        req_addr = a; req_len = l; req_valid = 1'b1;
        @(negedge PCLK);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge PCLK);
            if (done) break;
        end
    endtask

    task automatic test_reset();
        logic [63:0] o;
        PRESET = 1'b1; req_valid = 1'b0; req_addr = 0; req_len = 0; dout_ready = 1'b1;
        repeat (3) @(negedge PCLK);
        o = {req_ready, dout_valid, dout_data, done, err, apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA};
        vectors++;
        if (o !== {1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 3'b000, 16'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs got %h, required %h", o, {1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 3'b000, 16'h0, 32'h0});
        end
        PRESET = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic test_basic();
        int d0 = done_cnt;
        slave_clear(8'h56);
        push_setup(8'h09);
        push_bytes(1, 1, 8'h56);
        start_req(8'h09, 8'd1);
        wait_done(500);
        vectors++;
        if (err !== 2'd0) begin errors++; $display("FAIL basic_err got %0d, required 0", err); end
        repeat (3) @(negedge PCLK);
        vectors++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done got %0d pulses, required 1", done_cnt - d0); end
        vectors++;
        if (exp_q.size() != 0 || exp_bytes.size() != 0) begin
            errors++;
            $display("FAIL basic_left got %0d transfers %0d bytes outstanding, required 0", exp_q.size(), exp_bytes.size());
        end
    endtask

    task automatic test_busy_len5();
        int d0 = done_cnt;
        slave_clear(8'h56);
        busy_n = 15;
        push_setup(8'h21);
        push_bytes(5, -2, 8'h56);
        start_req(8'h21, 8'd5);
        wait_done(3000);
        repeat (3) @(negedge PCLK);
        vectors++;
        if (done_cnt - d0 != 1 || err !== 2'd0) begin
            errors++;
            $display("FAIL busy_done got %0d pulses err=%0d, required 1 pulse err=0", done_cnt - d0, err);
        end
        vectors++;
        if (exp_q.size() != 0 || exp_bytes.size() != 0) begin
            errors++;
            $display("FAIL busy_left got %0d transfers %0d bytes outstanding, required 0", exp_q.size(), exp_bytes.size());
        end
    endtask

    task automatic test_dout_stall();
        int d0 = done_cnt;
        int b0 = beats;
        int bad = 0;
        logic [7:0] held;
        slave_clear(8'h70);
        push_setup(8'h33);
        push_bytes(3, 1, 8'h70);
        start_req(8'h33, 8'd3);
        for (int i = 0; i < 1000 && beats - b0 < 1; i++) @(negedge PCLK);
        dout_ready = 1'b0;
        for (int i = 0; i < 1000 && !dout_valid; i++) @(negedge PCLK);
        held = dout_data;
        for (int i = 0; i < 20; i++) begin
            if (dout_valid !== 1'b1 || dout_data !== held || apb.PSEL !== 1'b0) bad++;
            @(negedge PCLK);
        end
        vectors++;
        if (bad != 0 || held !== 8'h71) begin
            errors++;
            $display("FAIL stall_hold got %0d unstable cycles byte=%h, required 0 unstable byte=71", bad, held);
        end
        dout_ready = 1'b1;
        wait_done(1000);
        repeat (3) @(negedge PCLK);
        vectors++;
        if (done_cnt - d0 != 1 || exp_bytes.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_end got %0d pulses %0d bytes left, required 1 pulse 0 left", done_cnt - d0, exp_bytes.size());
        end
    endtask

    task automatic test_pready_wait();
        int d0 = done_cnt;
        int cyc = 0;
        int bad = 0;
        slave_clear(8'h30);
        stall_en = 1; stall_val = 32'h18; stall_n = 3;
        push_setup(8'h18);
        push_bytes(1, 1, 8'h30);
        start_req(8'h18, 8'd1);
        for (int i = 0; i < 500; i++) begin
            if (apb.PSEL && apb.PENABLE && apb.PWRITE && apb.PWDATA == 32'h18) break;
            @(negedge PCLK);
        end
        while (apb.PENABLE && cyc < 20) begin
            if (apb.PADDR !== 16'h0004 || apb.PWDATA !== 32'h18 || apb.PWRITE !== 1'b1 || apb.PSEL !== 1'b1) bad++;
            cyc++;
            @(negedge PCLK);
        end
        vectors++;
        if (cyc != 4 || bad != 0) begin
            errors++;
            $display("FAIL pready_access got %0d ACCESS cycles %0d unstable, required 4 and 0", cyc, bad);
        end
        wait_done(1000);
        repeat (3) @(negedge PCLK);
        vectors++;
        if (done_cnt - d0 != 1 || err !== 2'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL pready_end got %0d pulses err=%0d %0d left, required 1 pulse err=0 0 left", done_cnt - d0, err, exp_q.size());
        end
    endtask

    task automatic test_slverr();
        int d0 = done_cnt;
        slave_clear(8'h00);
        slverr_en = 1; slverr_val = 32'h01;
        push_w(32'h00, 1);
        push_w(32'h0D, 1);
        push_w(32'h44, 1);
        push_w(32'h01, 0);
        start_req(8'h44, 8'd2);
        wait_done(500);
        vectors++;
        if (done !== 1'b1 || err !== 2'd1) begin
            errors++;
            $display("FAIL slverr_err got done=%0d err=%0d, required done=1 err=1", done, err);
        end
        @(negedge PCLK);
        vectors++;
        if (req_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL slverr_ready got req_ready=%0d done=%0d, required 1 and 0", req_ready, done);
        end
        repeat (10) @(negedge PCLK);
        vectors++;
        if (done_cnt - d0 != 1 || exp_q.size() != 0 || err !== 2'd1) begin
            errors++;
            $display("FAIL slverr_end got %0d pulses %0d left err=%0d, required 1 pulse 0 left err=1", done_cnt - d0, exp_q.size(), err);
        end
    endtask

    task automatic test_timeout();
        int d0 = done_cnt;
        slave_clear(8'h00);
        stuck = 1;
        push_w(32'h00, PM);
        start_req(8'h55, 8'd1);
        wait_done(500);
        vectors++;
        if (err !== 2'd2) begin errors++; $display("FAIL timeout_err got %0d, required 2", err); end
        repeat (5) @(negedge PCLK);
        vectors++;
        if (done_cnt - d0 != 1 || exp_q.size() != 0 || err !== 2'd2 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_end got %0d pulses %0d left err=%0d ready=%0d, required 1 0 2 1",
                     done_cnt - d0, exp_q.size(), err, req_ready);
        end
        stuck = 0;
    endtask

    task automatic test_reset_mid();
        logic [63:0] o;
        slave_clear(8'h00);
        stall_en = 1; stall_val = 32'h0D; stall_n = 10;
        push_setup(8'h66);
        start_req(8'h66, 8'd1);
        for (int i = 0; i < 500; i++) begin
            if (apb.PSEL && apb.PENABLE && apb.PWDATA == 32'h0D) break;
            @(negedge PCLK);
        end
        PRESET = 1'b1;
        @(negedge PCLK);
        o = {req_ready, dout_valid, dout_data, done, err, apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA};
        vectors++;
        if (o !== {1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 3'b000, 16'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid got %h, required %h", o, {1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 3'b000, 16'h0, 32'h0});
        end
        PRESET = 1'b0;
        exp_q.delete();
        exp_bytes.delete();
        run_active = 0;
        slave_clear(8'h00);
        @(negedge PCLK);
    endtask

    task automatic test_len0();
        int d0 = done_cnt;
        slave_clear(8'h99);
        push_setup(8'h7A);
        start_req(8'h7A, 8'd0);
        wait_done(500);
        vectors++;
        if (err !== 2'd0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL len0_err got err=%0d dout_valid=%0d, required 0 and 0", err, dout_valid);
        end
        repeat (3) @(negedge PCLK);
        vectors++;
        if (done_cnt - d0 != 1 || exp_q.size() != 0 || data_byte !== 8'h99) begin
            errors++;
            $display("FAIL len0_end got %0d pulses %0d left data_reads=%0d, required 1 0 0",
                     done_cnt - d0, exp_q.size(), data_byte - 8'h99);
        end
    endtask

    initial begin
        apb.PRDATA = 32'h0; apb.PREADY = 1'b0; apb.PSLVERR = 1'b0;
        test_reset();
        test_basic();
        test_busy_len5();
        test_dout_stall();
        test_pready_wait();
        test_slverr();
        test_timeout();
        test_reset_mid();
        test_len0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
